// File: rtl/bp_me_dram_dma_arbiter_if.sv
// Slice-side and DRAM-side streams of the DRAM DMA arbiter.
// slave = arbiter view, master = slices plus DRAM together.
interface bp_me_dram_dma_arbiter_if #(
    parameter int num_slices_p   = 2,
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64
);
    logic [num_slices_p*header_width_p-1:0] slice_cmd_header_i;
    logic [num_slices_p-1:0]                slice_cmd_write_i;
    logic [num_slices_p-1:0]                slice_cmd_header_v_i;
    logic [num_slices_p-1:0]                slice_cmd_header_yumi_o;
    logic [num_slices_p*data_width_p-1:0]   slice_cmd_data_i;
    logic [num_slices_p-1:0]                slice_cmd_data_v_i;
    logic [num_slices_p-1:0]                slice_cmd_data_yumi_o;
    logic [header_width_p-1:0]              slice_resp_header_o;
    logic [num_slices_p-1:0]                slice_resp_header_v_o;
    logic [num_slices_p-1:0]                slice_resp_header_ready_i;
    logic [data_width_p-1:0]                slice_resp_data_o;
    logic [num_slices_p-1:0]                slice_resp_data_v_o;
    logic [num_slices_p-1:0]                slice_resp_data_ready_i;
    logic [header_width_p-1:0]              dram_cmd_header_o;
    logic                                   dram_cmd_header_v_o;
    logic                                   dram_cmd_header_yumi_i;
    logic [data_width_p-1:0]                dram_cmd_data_o;
    logic                                   dram_cmd_data_v_o;
    logic                                   dram_cmd_data_yumi_i;
    logic [header_width_p-1:0]              dram_resp_header_i;
    logic                                   dram_resp_header_v_i;
    logic                                   dram_resp_header_ready_o;
    logic [data_width_p-1:0]                dram_resp_data_i;
    logic                                   dram_resp_data_v_i;
    logic                                   dram_resp_data_ready_o;

    modport slave (
        input  slice_cmd_header_i, slice_cmd_write_i, slice_cmd_header_v_i,
        output slice_cmd_header_yumi_o,
        input  slice_cmd_data_i, slice_cmd_data_v_i,
        output slice_cmd_data_yumi_o,
        output slice_resp_header_o, slice_resp_header_v_o,
        input  slice_resp_header_ready_i,
        output slice_resp_data_o, slice_resp_data_v_o,
        input  slice_resp_data_ready_i,
        output dram_cmd_header_o, dram_cmd_header_v_o,
        input  dram_cmd_header_yumi_i,
        output dram_cmd_data_o, dram_cmd_data_v_o,
        input  dram_cmd_data_yumi_i,
        input  dram_resp_header_i, dram_resp_header_v_i,
        output dram_resp_header_ready_o,
        input  dram_resp_data_i, dram_resp_data_v_i,
        output dram_resp_data_ready_o
    );

    modport master (
        output slice_cmd_header_i, slice_cmd_write_i, slice_cmd_header_v_i,
        input  slice_cmd_header_yumi_o,
        output slice_cmd_data_i, slice_cmd_data_v_i,
        input  slice_cmd_data_yumi_o,
        input  slice_resp_header_o, slice_resp_header_v_o,
        output slice_resp_header_ready_i,
        input  slice_resp_data_o, slice_resp_data_v_o,
        output slice_resp_data_ready_i,
        input  dram_cmd_header_o, dram_cmd_header_v_o,
        output dram_cmd_header_yumi_i,
        input  dram_cmd_data_o, dram_cmd_data_v_o,
        output dram_cmd_data_yumi_i,
        output dram_resp_header_i, dram_resp_header_v_i,
        input  dram_resp_header_ready_o,
        output dram_resp_data_i, dram_resp_data_v_i,
        input  dram_resp_data_ready_o
    );
endinterface

// File: rtl/bp_me_dram_dma_arbiter.sv
// Shares one DRAM stream link among L2 slice DMA ports; reads tracked in an order FIFO.
// Define BP_ME_DMA_ARB_FIXED_PRIORITY_EN for lowest-index-wins command arbitration.
module bp_me_dram_dma_arbiter #(
    parameter int num_slices_p      = 2,
    parameter int header_width_p    = 64,
    parameter int data_width_p      = 64,
    parameter int block_words_p     = 8,
    parameter int max_outstanding_p = 4
) (
    input logic clk_i,
    input logic reset_i,
    bp_me_dram_dma_arbiter_if.slave bus
);
    localparam int SW = $clog2(num_slices_p);
    localparam int PW = $clog2(max_outstanding_p);
    localparam int CW = $clog2(block_words_p);

    typedef enum logic {e_idle, e_wr_data} state_e;

    state_e state_r, state_n;
    logic [SW-1:0] gnt, wr_slice_r;
    logic [CW-1:0] cmd_cnt_r, resp_cnt_r;
    logic [SW-1:0] fifo_mem [max_outstanding_p];
    logic [PW-1:0] rd_ptr_r, wr_ptr_r, nxt_ptr;
    logic [PW:0] count_r;
    logic [max_outstanding_p-1:0] taken_r;
    logic [num_slices_p-1:0] elig;
    logic full, empty, cmd_any, hdr_hs, data_v, data_hs, cmd_last, push;
    logic [SW-1:0] d, d_nxt;
    logic active, hdr_head, hdr_next, hdr_ok, resp_last, data_ok;
    logic rhdr_hs, rdata_hs, pop;
    logic [PW-1:0] hdr_slot;

    assign full  = count_r == (PW+1)'(max_outstanding_p);
    assign empty = count_r == '0;

    always_comb begin
        for (int i = 0; i < num_slices_p; i++) begin
            elig[i] = bus.slice_cmd_header_v_i[i]
                    & (bus.slice_cmd_write_i[i] | ~full);
        end
    end

`ifdef BP_ME_DMA_ARB_FIXED_PRIORITY_EN
    always_comb begin
        gnt = '0;
        for (int i = num_slices_p - 1; i >= 0; i--) begin
            if (elig[i]) gnt = SW'(i);
        end
    end
`else
    logic [SW-1:0] rr_r;
    logic found;

    always_comb begin
        gnt = rr_r;
        found = 1'b0;
        for (int k = 0; k < num_slices_p; k++) begin
            if (!found && elig[(int'(rr_r) + k) % num_slices_p]) begin
                gnt = SW'((int'(rr_r) + k) % num_slices_p);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_r <= '0;
        end else if (hdr_hs) begin
            rr_r <= (int'(gnt) == num_slices_p - 1) ? '0 : gnt + 1'b1;
        end
    end
`endif

    // Command side: header arbitration, then a locked write-data burst
    assign cmd_any  = ~reset_i & (state_r == e_idle) & (|elig);
    assign hdr_hs   = cmd_any & bus.dram_cmd_header_yumi_i;
    assign push     = hdr_hs & ~bus.slice_cmd_write_i[gnt];
    assign data_v   = ~reset_i & (state_r == e_wr_data)
                    & bus.slice_cmd_data_v_i[wr_slice_r];
    assign data_hs  = data_v & bus.dram_cmd_data_yumi_i;
    assign cmd_last = cmd_cnt_r == CW'(block_words_p - 1);

    assign bus.dram_cmd_header_o =
        bus.slice_cmd_header_i[int'(gnt)*header_width_p +: header_width_p];
    assign bus.dram_cmd_header_v_o = cmd_any;
    assign bus.slice_cmd_header_yumi_o =
        hdr_hs ? (num_slices_p'(1) << gnt) : '0;
    assign bus.dram_cmd_data_o =
        bus.slice_cmd_data_i[int'(wr_slice_r)*data_width_p +: data_width_p];
    assign bus.dram_cmd_data_v_o = data_v;
    assign bus.slice_cmd_data_yumi_o =
        data_hs ? (num_slices_p'(1) << wr_slice_r) : '0;

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_idle: begin
                if (hdr_hs && bus.slice_cmd_write_i[gnt]) state_n = e_wr_data;
            end
            e_wr_data: begin
                if (data_hs && cmd_last) state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    // Response side: a header may run one entry ahead only toward the same slice
    assign nxt_ptr  = rd_ptr_r + 1'b1;
    assign d        = fifo_mem[rd_ptr_r];
    assign d_nxt    = fifo_mem[nxt_ptr];
    assign active   = ~reset_i & ~empty;
    assign hdr_head = ~taken_r[rd_ptr_r];
    assign hdr_next = taken_r[rd_ptr_r] & (count_r > (PW+1)'(1))
                    & (d_nxt == d) & ~taken_r[nxt_ptr];
    assign hdr_ok   = active & (hdr_head | hdr_next);
    assign hdr_slot = hdr_head ? rd_ptr_r : nxt_ptr;

    assign bus.slice_resp_header_o = bus.dram_resp_header_i;
    assign bus.slice_resp_header_v_o =
        (hdr_ok & bus.dram_resp_header_v_i) ? (num_slices_p'(1) << d) : '0;
    assign bus.dram_resp_header_ready_o =
        hdr_ok & bus.slice_resp_header_ready_i[d];
    assign rhdr_hs = bus.dram_resp_header_ready_o & bus.dram_resp_header_v_i;

    // The block's last beat cannot retire its entry ahead of its header
    assign resp_last = resp_cnt_r == CW'(block_words_p - 1);
    assign data_ok   = active & (~resp_last | taken_r[rd_ptr_r]
                                 | (rhdr_hs & hdr_head));

    assign bus.slice_resp_data_o = bus.dram_resp_data_i;
    assign bus.slice_resp_data_v_o =
        (data_ok & bus.dram_resp_data_v_i) ? (num_slices_p'(1) << d) : '0;
    assign bus.dram_resp_data_ready_o =
        data_ok & bus.slice_resp_data_ready_i[d];
    assign rdata_hs = bus.dram_resp_data_ready_o & bus.dram_resp_data_v_i;
    assign pop      = rdata_hs & resp_last;

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_r] <= gnt;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_idle;
            wr_slice_r <= '0;
            cmd_cnt_r  <= '0;
            resp_cnt_r <= '0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            taken_r    <= '0;
        end else begin
            state_r <= state_n;
            if (hdr_hs && bus.slice_cmd_write_i[gnt]) begin
                wr_slice_r <= gnt;
                cmd_cnt_r  <= '0;
            end else if (data_hs) begin
                cmd_cnt_r <= cmd_cnt_r + 1'b1;
            end
            if (rdata_hs) resp_cnt_r <= resp_cnt_r + 1'b1;
            if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop) rd_ptr_r <= nxt_ptr;
            count_r <= count_r + (PW+1)'(push) - (PW+1)'(pop);
            if (rhdr_hs) taken_r[hdr_slot] <= 1'b1;
            if (pop) taken_r[rd_ptr_r] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bp_me_dram_dma_arbiter.sv
// Randomized bench for bp_me_dram_dma_arbiter against a queue-based model.
// Honors BP_ME_DMA_ARB_FIXED_PRIORITY_EN like the design.
module tb_bp_me_dram_dma_arbiter;
    localparam int NS = 2;
    localparam int HW = 64;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int DEPTH = 4;
    localparam int CYCLES = 1400;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    bp_me_dram_dma_arbiter_if #(
        .num_slices_p(NS), .header_width_p(HW), .data_width_p(DW)
    ) bus ();

    bp_me_dram_dma_arbiter #(
        .num_slices_p(NS), .header_width_p(HW), .data_width_p(DW),
        .block_words_p(BW), .max_outstanding_p(DEPTH)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [NS-1:0] oh(input int i);
        logic [NS-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Model state: write lock, order queue of reading slices, header/beat progress
    int m_rr, m_ws, m_cnt, m_rcnt;
    bit m_wr, ht0, ht1;
    int q[$];

    logic [NS-1:0] hv, wr, dv, rh, rd, el;
    logic [HW-1:0] hdr [NS];
    logic [DW-1:0] dat [NS];
    logic dhv, ddv;
    logic [HW-1:0] dhdr;
    logic [DW-1:0] ddat;

    initial begin
        int p_hv, p_wr, p_resp, g, d;
        bit rst, any, hhs, dhs, hok, hhead, last, dok, rhhs, rdhs;
        bit ex_dv;
        logic [NS-1:0] ex_hy, ex_dy, ex_rhv, ex_rdv;
        bit ex_rhr, ex_rdr;

        m_rr = 0; m_wr = 0; m_ws = 0; m_cnt = 0; m_rcnt = 0;
        ht0 = 0; ht1 = 0;
        reset_i = 1'b1;
        bus.slice_cmd_header_i = '0;
        bus.slice_cmd_write_i = '0;
        bus.slice_cmd_header_v_i = '0;
        bus.slice_cmd_data_i = '0;
        bus.slice_cmd_data_v_i = '0;
        bus.slice_resp_header_ready_i = '0;
        bus.slice_resp_data_ready_i = '0;
        bus.dram_cmd_header_yumi_i = 1'b0;
        bus.dram_cmd_data_yumi_i = 1'b0;
        bus.dram_resp_header_i = '0;
        bus.dram_resp_header_v_i = 1'b0;
        bus.dram_resp_data_i = '0;
        bus.dram_resp_data_v_i = 1'b0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            rst = (cyc < 2) || (cyc == 260) || (cyc == 950);
            if (cyc < 400) begin
                p_hv = 70; p_wr = 30; p_resp = 70;
            end else if (cyc < 700) begin
                p_hv = 80; p_wr = 25; p_resp = 0;
            end else if (cyc < 1000) begin
                p_hv = 50; p_wr = 40; p_resp = 90;
            end else begin
                p_hv = 90; p_wr = 10; p_resp = 60;
            end

            for (int i = 0; i < NS; i++) begin
                hv[i] = $urandom_range(99) < p_hv;
                wr[i] = $urandom_range(99) < p_wr;
                dv[i] = $urandom_range(99) < 75;
                rh[i] = $urandom_range(99) < 80;
                rd[i] = $urandom_range(99) < 75;
                hdr[i] = {$urandom, $urandom};
                dat[i] = {$urandom, $urandom};
            end
            dhv = $urandom_range(99) < p_resp;
            ddv = $urandom_range(99) < p_resp;
            dhdr = {$urandom, $urandom};
            ddat = {$urandom, $urandom};

            reset_i = rst;
            bus.slice_cmd_write_i = wr;
            bus.slice_cmd_header_v_i = hv;
            bus.slice_cmd_data_v_i = dv;
            bus.slice_resp_header_ready_i = rh;
            bus.slice_resp_data_ready_i = rd;
            for (int i = 0; i < NS; i++) begin
                bus.slice_cmd_header_i[i*HW +: HW] = hdr[i];
                bus.slice_cmd_data_i[i*DW +: DW] = dat[i];
            end
            bus.dram_resp_header_i = dhdr;
            bus.dram_resp_header_v_i = dhv;
            bus.dram_resp_data_i = ddat;
            bus.dram_resp_data_v_i = ddv;

            // Command-side expectation
            for (int i = 0; i < NS; i++)
                el[i] = hv[i] && (wr[i] || q.size() < DEPTH);
            any = !rst && !m_wr && (el != '0);
            g = 0;
`ifdef BP_ME_DMA_ARB_FIXED_PRIORITY_EN
            for (int i = NS - 1; i >= 0; i--) if (el[i]) g = i;
`else
            for (int k = NS - 1; k >= 0; k--)
                if (el[(m_rr + k) % NS]) g = (m_rr + k) % NS;
`endif
            hhs = any && ($urandom_range(99) < 70);
            ex_dv = !rst && m_wr && dv[m_ws];
            dhs = ex_dv && ($urandom_range(99) < 70);
            bus.dram_cmd_header_yumi_i = hhs;
            bus.dram_cmd_data_yumi_i = dhs;
            ex_hy = hhs ? oh(g) : '0;
            ex_dy = dhs ? oh(m_ws) : '0;

            // Response-side expectation
            ex_rhv = '0; ex_rdv = '0; ex_rhr = 0; ex_rdr = 0;
            rhhs = 0; rdhs = 0; hhead = 0; d = 0;
            if (!rst && q.size() > 0) begin
                d = q[0];
                hhead = !ht0;
                hok = !ht0 || (q.size() > 1 && q[1] == d && !ht1);
                ex_rhr = hok && rh[d];
                ex_rhv = (hok && dhv) ? oh(d) : '0;
                rhhs = ex_rhr && dhv;
                last = (m_rcnt == BW - 1);
                dok = !last || ht0 || (rhhs && hhead);
                ex_rdr = dok && rd[d];
                ex_rdv = (dok && ddv) ? oh(d) : '0;
                rdhs = ex_rdr && ddv;
            end

            #1;
            chk("cmd_hdr_v", 64'(bus.dram_cmd_header_v_o), 64'(any));
            if (any) chk("cmd_hdr", bus.dram_cmd_header_o, hdr[g]);
            chk("cmd_hdr_yumi", 64'(bus.slice_cmd_header_yumi_o), 64'(ex_hy));
            chk("cmd_data_v", 64'(bus.dram_cmd_data_v_o), 64'(ex_dv));
            if (ex_dv) chk("cmd_data", bus.dram_cmd_data_o, dat[m_ws]);
            chk("cmd_data_yumi", 64'(bus.slice_cmd_data_yumi_o), 64'(ex_dy));
            chk("resp_hdr_v", 64'(bus.slice_resp_header_v_o), 64'(ex_rhv));
            chk("resp_hdr_rdy", 64'(bus.dram_resp_header_ready_o), 64'(ex_rhr));
            chk("resp_data_v", 64'(bus.slice_resp_data_v_o), 64'(ex_rdv));
            chk("resp_data_rdy", 64'(bus.dram_resp_data_ready_o), 64'(ex_rdr));
            if (ex_rdv != '0) chk("resp_data", bus.slice_resp_data_o, ddat);
            if (ex_rhv != '0) chk("resp_hdr", bus.slice_resp_header_o, dhdr);

            // Advance the model to the state after the coming edge
            if (rst) begin
                m_rr = 0; m_wr = 0; m_ws = 0; m_cnt = 0; m_rcnt = 0;
                ht0 = 0; ht1 = 0;
                q.delete();
            end else begin
                if (rhhs) begin
                    if (hhead) ht0 = 1; else ht1 = 1;
                end
                if (rdhs) begin
                    m_rcnt++;
                    if (m_rcnt == BW) begin
                        m_rcnt = 0;
                        void'(q.pop_front());
                        ht0 = ht1;
                        ht1 = 0;
                    end
                end
                if (dhs) begin
                    m_cnt++;
                    if (m_cnt == BW) m_wr = 0;
                end
                if (hhs) begin
                    m_rr = (g + 1) % NS;
                    if (wr[g]) begin
                        m_wr = 1; m_ws = g; m_cnt = 0;
                    end else begin
                        q.push_back(g);
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bp_me_dram_dma_arbiter.md
# bp_me_dram_dma_arbiter

- Shares one DRAM-side stream memory interface among `num_slices_p` L2 cache slices, one per slice DMA port.
- Command path: arbitrates command headers between slices and locks the grant for a full write-data burst.
- Response path: records the issuing slice of every read in an order FIFO and steers returning response header and data beats back to that slice.
- Position: between the slices' DMA-facing header/data streams and the single DRAM link.

## Interface
Parameters:
- `num_slices_p`, 2, number of requesting slices (≥2)
- `header_width_p`, 64, width of one DRAM memory-message header
- `data_width_p`, 64, width of one data beat (dword)
- `block_words_p`, 8, data beats per cache block (power of two)
- `max_outstanding_p`, 4, read-order FIFO depth (power of two)

Ports (`N = num_slices_p`). Clock is `clk_i`; reset is `reset_i`, synchronous and active-high.
- `clk_i`  in  1  clock
- `reset_i`  in  1  synchronous active-high reset
- `slice_cmd_header_i`  in  N*header_width_p  per-slice command header
- `slice_cmd_write_i`  in  N  per-slice 1 = header is a write
- `slice_cmd_header_v_i`  in  N  header valid
- `slice_cmd_header_yumi_o`  out  N  header consumed
- `slice_cmd_data_i`  in  N*data_width_p  write-data beat
- `slice_cmd_data_v_i`  in  N  beat valid
- `slice_cmd_data_yumi_o`  out  N  beat consumed
- `slice_resp_header_o`  out  header_width_p  broadcast response header
- `slice_resp_header_v_o`  out  N  one-hot header valid
- `slice_resp_header_ready_i`  in  N  slice header ready
- `slice_resp_data_o`  out  data_width_p  broadcast response beat
- `slice_resp_data_v_o`  out  N  one-hot beat valid
- `slice_resp_data_ready_i`  in  N  slice data ready
- `dram_cmd_header_o` / `_v_o` out, `dram_cmd_header_yumi_i` in  header_width_p/1/1  DRAM command header
- `dram_cmd_data_o` / `_v_o` out, `dram_cmd_data_yumi_i` in  data_width_p/1/1  DRAM write data
- `dram_resp_header_i` / `_v_i` in, `dram_resp_header_ready_o` out  header_width_p/1/1  DRAM response header
- `dram_resp_data_i` / `_v_i` in, `dram_resp_data_ready_o` out  data_width_p/1/1  DRAM response data

## Operation
Command FSM, states `e_idle` and `e_wr_data`.

`e_idle`:
- Eligible slice: `header_v` = 1 and (write, or order FIFO not full).
- Round-robin pick among eligible slices, starting at pointer `rr_r`.
- The winner's header drives `dram_cmd_header_o`; `dram_cmd_header_v_o` = any eligible.
- `slice_cmd_header_yumi_o[g]` = `dram_cmd_header_yumi_i`.
- On yumi:
  - `rr_r` ← g+1 mod N.
  - Read: push g into the order FIFO.
  - Write: latch g and go to `e_wr_data` with the beat counter cleared.

`e_wr_data`:
- Only slice g's data path is connected: `dram_cmd_data_v_o` = `slice_cmd_data_v_i[g]`, and the yumi is passed back to slice g.
- No header is granted in this state.
- After the `block_words_p`-th yumi, return to `e_idle`.
- In `e_idle`, all `slice_cmd_data_yumi_o` and `dram_cmd_data_v_o` are 0.

Response path:
- Active only while the FIFO is non-empty; destination d = FIFO head.
- Header: `slice_resp_header_v_o[d]` = `dram_resp_header_v_i`; `dram_resp_header_ready_o` = `slice_resp_header_ready_i[d]`.
- Data: same steering, with a separate beat counter.
- The FIFO pops on the handshake of the last (`block_words_p`-th) data beat.
- FIFO empty: both DRAM response readys are 0. Unsolicited responses stall and are not dropped.
- Writes generate no response and are not tracked.
- Response header and response data are independent. The header for read k+1 may be accepted before the data of read k completes, only if d is unchanged — the header is gated by a per-entry "header taken" flag.

Boundary conditions:
- Full FIFO: reads stay ineligible even if a pop occurs in the same cycle (no bypass). Writes may still win.
- Push and pop in the same cycle: both performed; count unchanged.
- Counters are `$clog2(block_words_p)` bits and wrap to 0 on the last beat.

## Timing
- All steering is combinational; DRAM-side and slice-side valid/ready have zero added latency.
- Grant and FSM transitions take effect the cycle after the yumi.
- Reset (at any point, including mid-burst or mid-response):
  - FSM → `e_idle`; `rr_r` = 0; FIFO emptied; both counters = 0; header-taken flag = 0.
  - While `reset_i` = 1, every `_v_o`, `_yumi_o` and `_ready_o` output is 0.
  - Partial bursts are abandoned; the surrounding system is reset together.

## Configuration
- `BP_ME_DMA_ARB_FIXED_PRIORITY_EN` defined: `e_idle` selection is fixed priority, lowest eligible index wins, and `rr_r` is removed.
- Undefined (default): round-robin as above.
- All other behaviour is identical.

## Test plan
- Single read, slice 1, addr 0x8000_0040, header accepted at t: FIFO = {1}; DRAM returns 8 beats 0..7 → only `slice_resp_data_v_o[1]` pulses 8 times; FIFO empty after beat 7.
- Slices 0 and 1 both present reads every cycle, `rr_r` = 0: grants alternate 0,1,0,1. Returned blocks route in issue order; data values are tagged per slice.
- Slice 0 write plus slice 1 read together: write granted; slice 1's header is not yumi'd until 8 write beats complete. Data-valid gaps (beat 3 held 2 cycles) do not release the lock.
- 4 reads issued with no responses (`max_outstanding_p` = 4): a 5th read is held; a write from the other slice is still granted; after the first block's last beat, the 5th read is accepted the next cycle.
- Backpressure: `slice_resp_data_ready_i[d]` = 0 for 3 cycles mid-block → `dram_resp_data_ready_o` = 0 for those cycles, no beat lost or duplicated.
- Reset asserted during write beat 4 and held 1 cycle → all outputs 0; next header from any slice is granted with counter 0 and FIFO empty.
